// File: rtl/puf_ctrl.sv
// -----------------------------------------------------------------------------
// puf_ctrl -- challenge/response sequencer for the bistable-ring PUF array.
//
// Steps an LFSR challenge sequence, which starts from a host seed. For each
// challenge it pulses the PUF reset, waits for the rings to settle and then
// samples the single response bit. It collects RESP_BITS bits into a response
// word and flags the completed word with a one-cycle valid pulse.
//
// Optional feature macro: PUF_VOTE_EN
//   When this macro is defined, each challenge is evaluated VOTES times and
//   the response bit is the majority of the samples. When it is undefined,
//   each challenge is evaluated once and no vote logic exists.
//
// Parameters:
//   RESP_BITS   response bits per run (2..64)
//   RST_CYC     cycles puf_reset is held high per evaluation (>=1)
//   SETTLE_CYC  cycles after puf_reset release before sampling (>=1)
//   VOTES       evaluations per challenge with PUF_VOTE_EN (odd, >=1)
//
// Ports:
//   clk         system clock, rising edge
//   reset_n     synchronous active-low reset
//   start       run request, honoured in IDLE only
//   seed        initial challenge, latched on accepted start (0 -> 1)
//   length_sel  ring length select, latched on accepted start
//   puf_out     response bit from the PUF (synchronous to clk)
//   puf_reset   PUF reset, high holds the rings in reset
//   puf_length  PUF ring length
//   puf_c       PUF 128-bit challenge
//   busy        high while a run is in progress
//   resp        assembled response, first bit ends up at the MSB
//   resp_valid  one-cycle pulse when resp is complete
// -----------------------------------------------------------------------------
module puf_ctrl #(
    parameter int RESP_BITS  = 32,
    parameter int RST_CYC    = 4,
    parameter int SETTLE_CYC = 16,
    parameter int VOTES      = 3
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 start,
    input  logic [127:0]         seed,
    input  logic [1:0]           length_sel,
    input  logic                 puf_out,
    output logic                 puf_reset,
    output logic [1:0]           puf_length,
    output logic [127:0]         puf_c,
    output logic                 busy,
    output logic [RESP_BITS-1:0] resp,
    output logic                 resp_valid
);

    localparam int CYC_MAX = (RST_CYC > SETTLE_CYC) ? RST_CYC : SETTLE_CYC;
    localparam int CW      = $clog2(CYC_MAX + 1);
    localparam int BW      = $clog2(RESP_BITS);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RST,
        S_EVAL,
        S_SAMPLE,
        S_DONE
    } state_t;

    state_t                 state_q, state_d;
    logic [CW-1:0]          cyc_q, cyc_d;
    logic [BW-1:0]          bit_q, bit_d;
    logic [127:0]           puf_c_q, puf_c_d;
    logic [1:0]             len_q, len_d;
    logic [RESP_BITS-1:0]   resp_q, resp_d;

    logic [127:0]           lfsr_next;
    logic                   commit;      // response bit for this challenge is final
    logic                   resp_bit;

`ifdef PUF_VOTE_EN
    localparam int VW  = $clog2(VOTES + 1);
    localparam int VCW = (VOTES > 1) ? $clog2(VOTES) : 1;

    logic [VW-1:0]          ones_q, ones_d;
    logic [VW-1:0]          ones_sum;
    logic [VCW-1:0]         vote_q, vote_d;
`else
    // Without voting, VOTES only takes part in this empty range check.
    if (VOTES < 1) begin : g_votes_range
    end
`endif

    // Fibonacci LFSR, taps 128/126/101/99.
    assign lfsr_next = {puf_c_q[126:0],
                        puf_c_q[127] ^ puf_c_q[125] ^ puf_c_q[100] ^ puf_c_q[98]};

    // ---------------------------------------------------------------------
    // State register
    // ---------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            cyc_q   <= '0;
            bit_q   <= '0;
            puf_c_q <= '0;
            len_q   <= '0;
            resp_q  <= '0;
`ifdef PUF_VOTE_EN
            ones_q  <= '0;
            vote_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            cyc_q   <= cyc_d;
            bit_q   <= bit_d;
            puf_c_q <= puf_c_d;
            len_q   <= len_d;
            resp_q  <= resp_d;
`ifdef PUF_VOTE_EN
            ones_q  <= ones_d;
            vote_q  <= vote_d;
`endif
        end
    end

    // ---------------------------------------------------------------------
    // Next-state logic
    // ---------------------------------------------------------------------
    always_comb begin
        state_d  = state_q;
        cyc_d    = cyc_q;
        bit_d    = bit_q;
        puf_c_d  = puf_c_q;
        len_d    = len_q;
        resp_d   = resp_q;
        commit   = 1'b0;
        resp_bit = puf_out;
`ifdef PUF_VOTE_EN
        ones_d   = ones_q;
        vote_d   = vote_q;
        ones_sum = ones_q + VW'(puf_out);
`endif

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_RST;
                    // An all-zero seed would lock the LFSR at zero.
                    puf_c_d = (seed == '0) ? 128'h1 : seed;
                    len_d   = length_sel;
                    resp_d  = '0;
                    bit_d   = '0;
                    cyc_d   = '0;
`ifdef PUF_VOTE_EN
                    ones_d  = '0;
                    vote_d  = '0;
`endif
                end
            end

            S_RST: begin
                if (cyc_q == CW'(RST_CYC - 1)) begin
                    cyc_d   = '0;
                    state_d = S_EVAL;
                end else begin
                    cyc_d = cyc_q + 1'b1;
                end
            end

            S_EVAL: begin
                if (cyc_q == CW'(SETTLE_CYC - 1)) begin
                    cyc_d   = '0;
                    state_d = S_SAMPLE;
                end else begin
                    cyc_d = cyc_q + 1'b1;
                end
            end

            S_SAMPLE: begin
`ifdef PUF_VOTE_EN
                if (vote_q != VCW'(VOTES - 1)) begin
                    // More votes to take on the same challenge.
                    ones_d  = ones_sum;
                    vote_d  = vote_q + 1'b1;
                    state_d = S_RST;
                end else begin
                    resp_bit = (ones_sum > VW'(VOTES / 2));
                    ones_d   = '0;
                    vote_d   = '0;
                    commit   = 1'b1;
                end
`else
                commit = 1'b1;
`endif
                if (commit) begin
                    resp_d = {resp_q[RESP_BITS-2:0], resp_bit};
                    if (bit_q == BW'(RESP_BITS - 1)) begin
                        state_d = S_DONE;
                    end else begin
                        bit_d   = bit_q + 1'b1;
                        puf_c_d = lfsr_next;
                        state_d = S_RST;
                    end
                end
            end

            S_DONE: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // ---------------------------------------------------------------------
    // Outputs
    // ---------------------------------------------------------------------
    // The rings are released only while settling and sampling.
    assign puf_reset  = !((state_q == S_EVAL) || (state_q == S_SAMPLE));
    assign busy       = (state_q == S_RST) || (state_q == S_EVAL) || (state_q == S_SAMPLE);
    assign resp_valid = (state_q == S_DONE);
    assign puf_length = len_q;
    assign puf_c      = puf_c_q;
    assign resp       = resp_q;

endmodule

// File: tb/tb_puf_ctrl.sv
// -----------------------------------------------------------------------------
// Testbench for puf_ctrl (RESP_BITS=8, RST_CYC=4, SETTLE_CYC=8, VOTES=3).
// A run is modelled as a flat cycle index from the accept edge. From that
// index the bench derives the evaluation slot, its offset, the current
// challenge and when the PUF bit is sampled. A compare process checks every
// output on every falling edge. Literal expectations pin the model.
// -----------------------------------------------------------------------------
module tb_puf_ctrl;

    localparam int RB = 8;
    localparam int RC = 4;
    localparam int SC = 8;
    localparam int VT = 3;
`ifdef PUF_VOTE_EN
    localparam int EV      = VT;
    localparam int EXP_LAT = 312;
`else
    localparam int EV      = 1;
    localparam int EXP_LAT = 104;
`endif
    localparam int P = RC + SC + 1;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          start;
    logic [127:0]  seed;
    logic [1:0]    length_sel;
    logic          puf_out;
    logic          puf_reset;
    logic [1:0]    puf_length;
    logic [127:0]  puf_c;
    logic          busy;
    logic [RB-1:0] resp;
    logic          resp_valid;

    int errors = 0;
    int checks = 0;
    bit chk_en = 1'b0;

    // Behavioural model state
    bit            m_active = 1'b0;
    bit            m_valid  = 1'b0;
    int            m_cyc    = 0;
    logic [127:0]  m_c      = '0;
    logic [1:0]    m_len    = '0;
    logic [RB-1:0] m_resp   = '0;
    int            m_ones   = 0;

    // puf_out stimulus control
    bit tie_en  = 1'b0;
    bit tie_val = 1'b0;
    bit pat_q[$];

    puf_ctrl #(
        .RESP_BITS (RB),
        .RST_CYC   (RC),
        .SETTLE_CYC(SC),
        .VOTES     (VT)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .start     (start),
        .seed      (seed),
        .length_sel(length_sel),
        .puf_out   (puf_out),
        .puf_reset (puf_reset),
        .puf_length(puf_length),
        .puf_c     (puf_c),
        .busy      (busy),
        .resp      (resp),
        .resp_valid(resp_valid)
    );

    always #5 clk = ~clk;

    function automatic logic [127:0] lfsr(input logic [127:0] c);
        return {c[126:0], c[127] ^ c[125] ^ c[100] ^ c[98]};
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // Model: a run is a flat cycle index m. Slot m/P is one evaluation,
    // offset m%P < RC is reset, and offset P-1 is the sample cycle.
    initial forever begin
        @(posedge clk);
        if (!reset_n) begin
            m_active = 1'b0; m_valid = 1'b0; m_cyc = 0;
            m_c = '0; m_len = '0; m_resp = '0; m_ones = 0;
        end else if (m_valid) begin
            m_valid = 1'b0;
        end else if (!m_active) begin
            if (start) begin
                m_active = 1'b1;
                m_cyc    = 0;
                m_c      = (seed == '0) ? 128'h1 : seed;
                m_len    = length_sel;
                m_resp   = '0;
                m_ones   = 0;
            end
        end else begin
            if (m_cyc % P == P - 1) begin
                m_ones += int'(puf_out);
                if ((m_cyc / P) % EV == EV - 1) begin
                    m_resp = {m_resp[RB-2:0], (2 * m_ones > EV)};
                    m_ones = 0;
                    if ((m_cyc / P) / EV == RB - 1) begin
                        m_active = 1'b0;
                        m_valid  = 1'b1;
                    end else begin
                        m_c = lfsr(m_c);
                    end
                end
            end
            m_cyc++;
        end
    end

    // puf_out driver: pattern bits go to sample cycles. Other cycles get
    // random values, which must be ignored.
    initial forever begin
        @(negedge clk);
        #2;
        if (m_active && (m_cyc % P == P - 1) && pat_q.size() > 0)
            puf_out = pat_q.pop_front();
        else if (tie_en)
            puf_out = tie_val;
        else
            puf_out = 1'($urandom_range(0, 1));
    end

    // Per-cycle comparison against the model
    initial forever begin
        @(negedge clk);
        if (chk_en) begin
            chk("cyc_puf_reset", 128'(puf_reset), 128'(m_active ? (m_cyc % P < RC) : 1'b1));
            chk("cyc_busy", 128'(busy), 128'(m_active));
            chk("cyc_resp_valid", 128'(resp_valid), 128'(m_valid));
            chk("cyc_puf_c", puf_c, m_c);
            chk("cyc_puf_length", 128'(puf_length), 128'(m_len));
            chk("cyc_resp", 128'(resp), 128'(m_resp));
        end
    end

    // Assert start for one cycle and return in cycle 0 after the accept edge.
    task automatic start_run(input logic [127:0] s, input logic [1:0] l);
        @(negedge clk); #1;
        seed = s; length_sel = l; start = 1'b1;
        @(negedge clk); #1;
        start = 1'b0;
    endtask

    // Wait for resp_valid. n0 is the current cycle index since accept.
    task automatic wait_done(input int n0, output int n);
        n = n0;
        while (resp_valid !== 1'b1 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (resp_valid !== 1'b1) begin
            checks++; errors++;
            $display("FAIL wait_done timeout: got no resp_valid expected pulse");
        end
    endtask

    int n, hi, lo, seen;
    logic [RB-1:0] pat_b2;

    initial begin
        reset_n = 1'b0; start = 1'b0; seed = '0; length_sel = '0; puf_out = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_en = 1'b1;
        chk("rst_puf_reset", 128'(puf_reset), 128'(1'b1));
        chk("rst_busy", 128'(busy), 128'(1'b0));
        chk("rst_puf_c", puf_c, 128'h0);
        chk("rst_resp", 128'(resp), 128'h0);
        #1 reset_n = 1'b1;

        // 1: all-ones response, LFSR from 1
        tie_en = 1'b1; tie_val = 1'b1;
        start_run(128'h1, 2'b01);
        chk("t1_busy", 128'(busy), 128'(1'b1));
        chk("t1_first_c", puf_c, 128'h1);
        repeat (P * EV) @(negedge clk);
        chk("t1_second_c", puf_c, 128'h2);
        wait_done(P * EV, n);
        chk("t1_latency", 128'(n), 128'(EXP_LAT));
        chk("t1_resp", 128'(resp), 128'hFF);
        tie_en = 1'b0;

        // 2: response 8'hB2. With voting, a 1 bit is voted 1,0,1 and a 0
        // bit is voted 0,0,1.
        pat_b2 = 8'hB2;
        for (int i = RB - 1; i >= 0; i--) begin
            if (EV == 1) begin
                pat_q.push_back(pat_b2[i]);
            end else begin
                pat_q.push_back(pat_b2[i]);
                pat_q.push_back(1'b0);
                pat_q.push_back(1'b1);
            end
        end
        start_run(128'h1234_5678_9abc_def0_0fed_cba9_8765_4321, 2'b11);
        hi = 0; lo = 0;
        for (int i = 0; i < P; i++) begin
            if (puf_reset) hi++; else lo++;
            @(negedge clk);
        end
        chk("t2_reset_hi_cycles", 128'(hi), 128'd4);
        chk("t2_reset_lo_cycles", 128'(lo), 128'd9);
        wait_done(P, n);
        chk("t2_latency", 128'(n), 128'(EXP_LAT));
        chk("t2_resp", 128'(resp), 128'hB2);

        // 3: zero seed, length latched
        start_run(128'h0, 2'b10);
        chk("t3_first_c", puf_c, 128'h1);
        repeat (20) @(negedge clk);
        #1 length_sel = 2'b00; seed = {$urandom(), $urandom(), $urandom(), $urandom()};
        wait_done(20, n);
        chk("t3_latency", 128'(n), 128'(EXP_LAT));
        chk("t3_length", 128'(puf_length), 128'h2);

        // 4a: start while busy is ignored
        start_run({$urandom(), $urandom(), $urandom(), $urandom()}, 2'b01);
        repeat (30) @(negedge clk);
        #1 start = 1'b1;
        repeat (5) @(negedge clk);
        #1 start = 1'b0;
        wait_done(35, n);
        chk("t4_latency_busy_start", 128'(n), 128'(EXP_LAT));

        // 4b: reset at bit 3 aborts the run
        start_run({$urandom(), $urandom(), $urandom(), $urandom()}, 2'b11);
        repeat (3 * P * EV) @(negedge clk);
        #1 reset_n = 1'b0;
        pat_q.delete();
        @(negedge clk);
        chk("t4_abort_puf_reset", 128'(puf_reset), 128'(1'b1));
        chk("t4_abort_busy", 128'(busy), 128'(1'b0));
        chk("t4_abort_resp", 128'(resp), 128'h0);
        #1 reset_n = 1'b1;
        seen = 0;
        for (int i = 0; i < EXP_LAT; i++) begin
            @(negedge clk);
            if (resp_valid) seen++;
        end
        chk("t4_no_valid_after_abort", 128'(seen), 128'h0);

        // 6: back-to-back runs
        tie_en = 1'b1; tie_val = 1'b1;
        start_run(128'h5, 2'b00);
        wait_done(0, n);
        tie_en = 1'b0;
        start_run(128'h9, 2'b01);
        chk("t6_busy", 128'(busy), 128'(1'b1));
        chk("t6_resp_cleared", 128'(resp), 128'h0);
        wait_done(0, n);
        chk("t6_latency", 128'(n), 128'(EXP_LAT));

        // Random runs: random seeds, responses, and mid-run input churn
        for (int r = 0; r < 4; r++) begin
            start_run({$urandom(), $urandom(), $urandom(), $urandom()}, 2'($urandom_range(0, 3)));
            n = 0;
            while (resp_valid !== 1'b1 && n < 2000) begin
                @(negedge clk);
                n++;
                #1;
                start      = 1'($urandom_range(0, 1));
                seed       = {$urandom(), $urandom(), $urandom(), $urandom()};
                length_sel = 2'($urandom_range(0, 3));
                if (resp_valid === 1'b1) start = 1'b0;
            end
            start = 1'b0;
            chk("rnd_latency", 128'(n), 128'(EXP_LAT));
        end

        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
